arith_arbiter: RTL and testbench

- Shares one N-bit signed arithmetic datapath (add/sub/negate plus compare flags) between two requesters.
- Arbitration is round-robin; both sides use valid/ready handshakes.
- Operands are captured, executed in one registered cycle, and returned with the requester ID and the full flag set.
- Sits between the control/decode logic and the arithmetic unit in the ALU top level.

---
 rtl/arith_arbiter.sv | 166 ++++++++++++++++
 tb/tb_arith_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/arith_arbiter.sv
// Round-robin arbiter sharing one registered N-bit signed add/sub/neg datapath between two requesters.
// Optional grant statistics counters are enabled by defining ARITH_ARB_STATS_EN.
module arith_arbiter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic [1:0]   req0_op,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic [1:0]   req1_op,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_result,
    output logic         rsp_carry,
    output logic         rsp_ovf,
    output logic         rsp_zero,
    output logic         rsp_lt,
    output logic         rsp_gt,
    output logic         rsp_eq
`ifdef ARITH_ARB_STATS_EN
    ,
    output logic [15:0]  grant_cnt0,
    output logic [15:0]  grant_cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t       state;
    state_t       state_next;
    logic         rr_ptr;
    logic [N-1:0] a_q;
    logic [N-1:0] b_q;
    logic [1:0]   op_q;
    logic         id_q;

    logic         grant0;
    logic         grant1;
    logic         is_add;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         cin;
    logic [N:0]   sum;
    logic         ovf;

    // Grants only in IDLE; rr_ptr breaks the tie when both requesters are valid.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE && !rst) begin
            if (req0_valid && (!req1_valid || !rr_ptr)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Overflow for NEG deliberately uses the captured A sign, like SUB.
    always_comb begin
        is_add = ~op_q[0];
        x      = (op_q == 2'b11) ? '0 : a_q;
        y      = is_add ? b_q : ~b_q;
        cin    = ~is_add;
        sum    = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, cin};
        if (is_add) begin
            ovf = (a_q[N-1] == b_q[N-1]) && (sum[N-1] != a_q[N-1]);
        end else begin
            ovf = (a_q[N-1] != b_q[N-1]) && (sum[N-1] != a_q[N-1]);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant0 || grant1) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= 2'b00;
            id_q       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_ovf    <= 1'b0;
            rsp_zero   <= 1'b0;
            rsp_lt     <= 1'b0;
            rsp_gt     <= 1'b0;
            rsp_eq     <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (grant0) begin
                        a_q  <= req0_a;
                        b_q  <= req0_b;
                        op_q <= req0_op;
                        id_q <= 1'b0;
                    end else if (grant1) begin
                        a_q  <= req1_a;
                        b_q  <= req1_b;
                        op_q <= req1_op;
                        id_q <= 1'b1;
                    end
                end
                EXEC: begin
                    rsp_valid  <= 1'b1;
                    rsp_id     <= id_q;
                    rsp_result <= sum[N-1:0];
                    rsp_carry  <= sum[N];
                    rsp_ovf    <= ovf;
                    rsp_zero   <= (sum[N-1:0] == '0);
                    rsp_lt     <= ($signed(a_q) <  $signed(b_q));
                    rsp_gt     <= ($signed(a_q) >  $signed(b_q));
                    rsp_eq     <= (a_q == b_q);
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rr_ptr    <= ~rsp_id;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ARITH_ARB_STATS_EN
    // Saturating per-requester accept counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt0 <= 16'h0000;
            grant_cnt1 <= 16'h0000;
        end else begin
            if (grant0 && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
            if (grant1 && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_arith_arbiter.sv
// Scoreboard bench for arith_arbiter: directed test-plan cases plus randomized traffic
// checked against an integer-arithmetic reference model. Build with ARITH_ARB_STATS_EN to cover counters.
module tb_arith_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_a = 8'h00, req0_b = 8'h00, req1_a = 8'h00, req1_b = 8'h00;
    logic [1:0] req0_op = 2'b00, req1_op = 2'b00;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic       rsp_id;
    logic [7:0] rsp_result;
    logic       rsp_carry, rsp_ovf, rsp_zero, rsp_lt, rsp_gt, rsp_eq;
`ifdef ARITH_ARB_STATS_EN
    logic [15:0] grant_cnt0, grant_cnt1;
`endif

    arith_arbiter #(.N(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_carry(rsp_carry), .rsp_ovf(rsp_ovf), .rsp_zero(rsp_zero),
        .rsp_lt(rsp_lt), .rsp_gt(rsp_gt), .rsp_eq(rsp_eq)
`ifdef ARITH_ARB_STATS_EN
        , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       id;
        logic [7:0] result;
        logic       carry;
        logic       ovf;
        logic       zero;
        logic       lt;
        logic       gt;
        logic       eq;
    } rsp_t;

    int   total = 0;
    int   bad = 0;
    rsp_t sb[$];
    logic m_busy = 1'b0;
    logic m_ptr = 1'b0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   m_cnt0 = 0, m_cnt1 = 0;
    logic acc0 = 1'b0, acc1 = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model written from the arithmetic rules in plain integers.
    function automatic rsp_t model(input logic id, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        rsp_t r;
        int ia = $signed(a);
        int ib = $signed(b);
        int ua = a;
        int ub = b;
        int t;
        case (op)
            2'b01: begin t = ia - ib; r.carry = (ua >= ub); r.ovf = (t < -128) || (t > 127); end
            2'b11: begin t = -ib; r.carry = (ub == 0); r.ovf = (a[7] != b[7]) && (t[7] != a[7]); end
            default: begin t = ia + ib; r.carry = (ua + ub) > 255; r.ovf = (t < -128) || (t > 127); end
        endcase
        r.id     = id;
        r.result = t[7:0];
        r.zero   = (t[7:0] == 8'h00);
        r.lt     = ia < ib;
        r.gt     = ia > ib;
        r.eq     = ia == ib;
        return r;
    endfunction

    always @(posedge clk) begin
        acc0 <= req0_valid && req0_ready;
        acc1 <= req1_valid && req1_ready;
    end

    // Monitor: predicts grants and response timing, pops and compares responses.
    always @(negedge clk) begin
        logic exp_r0, exp_r1, exp_v;
        rsp_t got;
        cyc++;
        exp_r0 = 1'b0;
        exp_r1 = 1'b0;
        if (!rst && !m_busy) begin
            if (req0_valid && (!req1_valid || m_ptr == 1'b0)) exp_r0 = 1'b1;
            else if (req1_valid) exp_r1 = 1'b1;
        end
        checkOutput("req_ready", {30'd0, req0_ready, req1_ready}, {30'd0, exp_r0, exp_r1});
        exp_v = m_busy && (cyc - acc_cyc >= 2);
        checkOutput("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_v});
        if (exp_v && rsp_valid && sb.size() > 0) begin
            got = {rsp_id, rsp_result, rsp_carry, rsp_ovf, rsp_zero, rsp_lt, rsp_gt, rsp_eq};
            checkOutput("rsp_fields", {17'd0, got}, {17'd0, sb[0]});
        end
        if (rst) begin
            m_busy = 1'b0;
            m_ptr  = 1'b0;
            m_cnt0 = 0;
            m_cnt1 = 0;
            sb.delete();
        end else begin
            if (exp_v && rsp_ready && sb.size() > 0) begin
                m_ptr = ~sb[0].id;
                void'(sb.pop_front());
                m_busy = 1'b0;
            end
            if (exp_r0) begin
                sb.push_back(model(1'b0, req0_a, req0_b, req0_op));
                m_busy = 1'b1; acc_cyc = cyc; m_cnt0++;
            end else if (exp_r1) begin
                sb.push_back(model(1'b1, req1_a, req1_b, req1_op));
                m_busy = 1'b1; acc_cyc = cyc; m_cnt1++;
            end
        end
    end

    task automatic drive(input bit side, input logic v, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        if (side) begin
            req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
        end
    endtask

    task automatic waitAcc(input bit side);
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge clk); #1;
            ok = side ? acc1 : acc0;
        end
        if (!ok) begin
            total++; bad++;
            $display("[TB] FAIL accept_timeout side=%0d got=none exp=accept within 40 cycles", side);
        end
    endtask

    task automatic applyStimulus(input bit side, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        drive(side, 1'b1, a, b, op);
        waitAcc(side);
        drive(side, 1'b0, a, b, op);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int   order[$];
        time  acc_t[$];
        bit   v0, v1;

        // Reset with both requesters asserting valid.
        drive(0, 1'b1, 8'd100, 8'd27, 2'b00);
        drive(1, 1'b1, 8'd127, 8'd1, 2'b00);
        @(posedge clk); #1;
        checkOutput("ready_in_reset", {30'd0, req0_ready, req1_ready}, 32'd0);
        @(posedge clk); #1;
        checkOutput("reset_rsp", {20'd0, rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_ovf, rsp_zero, rsp_lt, rsp_gt, rsp_eq}, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("first_grant", {30'd0, req0_ready, req1_ready}, 32'd2);

        waitAcc(0);
        drive(0, 1'b0, 8'd0, 8'd0, 2'b00);
        @(posedge clk); #1;
        checkOutput("add_valid_id", {30'd0, rsp_valid, rsp_id}, 32'd2);
        checkOutput("add_result", {24'd0, rsp_result}, 32'd127);
        checkOutput("add_flags", {26'd0, rsp_carry, rsp_ovf, rsp_zero, rsp_lt, rsp_gt, rsp_eq}, 32'b000010);

        waitAcc(1);
        drive(1, 1'b0, 8'd0, 8'd0, 2'b00);
        idleCycles(3);

        applyStimulus(0, 8'hFF, 8'h01, 2'b00);
        applyStimulus(1, 8'h80, 8'h01, 2'b01);
        applyStimulus(0, 8'h00, 8'd5, 2'b11);
        applyStimulus(1, 8'h33, 8'h7A, 2'b10);
        idleCycles(4);

        // Round-robin with both valid continuously.
        drive(0, 1'b1, 8'($urandom), 8'($urandom), 2'($urandom));
        drive(1, 1'b1, 8'($urandom), 8'($urandom), 2'($urandom));
        for (int i = 0; i < 40 && order.size() < 4; i++) begin
            @(posedge clk); #1;
            if (acc0) begin order.push_back(0); acc_t.push_back($time); drive(0, 1'b1, 8'($urandom), 8'($urandom), 2'($urandom)); end
            if (acc1) begin order.push_back(1); acc_t.push_back($time); drive(1, 1'b1, 8'($urandom), 8'($urandom), 2'($urandom)); end
        end
        drive(0, 1'b0, 8'd0, 8'd0, 2'b00);
        drive(1, 1'b0, 8'd0, 8'd0, 2'b00);
        checkOutput("rr_count", order.size(), 4);
        for (int i = 0; i < order.size(); i++) checkOutput("rr_order", order[i], i % 2);
        for (int i = 1; i < acc_t.size(); i++) checkOutput("rr_spacing", 32'(acc_t[i] - acc_t[i-1]), 30);
        idleCycles(4);

        // Backpressure: response must hold and nothing else may be granted.
        rsp_ready = 1'b0;
        applyStimulus(0, 8'h5A, 8'hC3, 2'b01);
        drive(1, 1'b1, 8'h11, 8'h22, 2'b00);
        idleCycles(7);
        checkOutput("bp_hold", {30'd0, rsp_valid, req1_ready}, 32'd2);
        rsp_ready = 1'b1;
        waitAcc(1);
        drive(1, 1'b0, 8'd0, 8'd0, 2'b00);
        idleCycles(4);

        // Leave rr_ptr at 1, then reset while requester 1's response is held.
        applyStimulus(0, 8'h01, 8'h02, 2'b00);
        idleCycles(4);
        rsp_ready = 1'b0;
        applyStimulus(1, 8'h40, 8'h40, 2'b01);
        idleCycles(2);
        rst = 1'b1;
        idleCycles(1);
        rst = 1'b0;
        checkOutput("rst_in_resp", {31'd0, rsp_valid}, 32'd0);
        rsp_ready = 1'b1;
        drive(0, 1'b1, 8'h09, 8'h07, 2'b01);
        drive(1, 1'b1, 8'h07, 8'h09, 2'b01);
        #1;
        checkOutput("rr_after_rst", {30'd0, req0_ready, req1_ready}, 32'd2);
        waitAcc(0);
        drive(0, 1'b0, 8'd0, 8'd0, 2'b00);
        waitAcc(1);
        drive(1, 1'b0, 8'd0, 8'd0, 2'b00);
        idleCycles(4);

        // Randomized traffic: drops before grant, payload churn, random backpressure.
        v0 = 1'b0; v1 = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            rsp_ready = ($urandom_range(0, 9) < 7);
            if (acc0) v0 = $urandom_range(0, 1);
            else if (v0) v0 = ($urandom_range(0, 9) != 0);
            else v0 = ($urandom_range(0, 2) == 0);
            if (acc1) v1 = $urandom_range(0, 1);
            else if (v1) v1 = ($urandom_range(0, 9) != 0);
            else v1 = ($urandom_range(0, 2) == 0);
            if (acc0 || $urandom_range(0, 2) == 0) drive(0, v0, 8'($urandom), 8'($urandom), 2'($urandom));
            else req0_valid = v0;
            if (acc1 || $urandom_range(0, 2) == 0) drive(1, v1, 8'($urandom), 8'($urandom), 2'($urandom));
            else req1_valid = v1;
        end
        drive(0, 1'b0, 8'd0, 8'd0, 2'b00);
        drive(1, 1'b0, 8'd0, 8'd0, 2'b00);
        rsp_ready = 1'b1;
        idleCycles(8);
        checkOutput("sb_drained", sb.size(), 0);
`ifdef ARITH_ARB_STATS_EN
        checkOutput("grant_cnt0", {16'd0, grant_cnt0}, m_cnt0);
        checkOutput("grant_cnt1", {16'd0, grant_cnt1}, m_cnt1);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
